// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: CP0 exception codes,
// exception flag bit positions, FSM state encoding and default vector.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam int NUM_FLAGS        = 9;
  localparam int FLAG_ADEL_FETCH  = 0;
  localparam int FLAG_RI          = 1;
  localparam int FLAG_OV          = 2;
  localparam int FLAG_TRAP        = 3;
  localparam int FLAG_SYSCALL     = 4;
  localparam int FLAG_BREAK       = 5;
  localparam int FLAG_ADEL_DATA   = 6;
  localparam int FLAG_ADES_DATA   = 7;
  localparam int FLAG_ERET        = 8;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    FLUSH,
    REDIRECT
  } exc_state_e;

  typedef enum logic [1:0] {
    BAD_NONE,
    BAD_PC,
    BAD_ADDR
  } bad_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority cause encoder: picks one exception code from the pending
// interrupt and per-instruction flags, plus which value feeds BadVAddr.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic                 int_pend,
  output logic [4:0]           code,
  output bad_sel_e             bad_sel
);

  // Interrupts win; the remaining causes follow MIPS order, lowest flag bit first
  always_comb begin
    code    = '0;
    bad_sel = BAD_NONE;
    if (int_pend) begin
      code = EXC_INT;
    end else if (flags[FLAG_ADEL_FETCH]) begin
      code    = EXC_ADEL;
      bad_sel = BAD_PC;
    end else if (flags[FLAG_RI]) begin
      code = EXC_RI;
    end else if (flags[FLAG_OV]) begin
      code = EXC_OV;
    end else if (flags[FLAG_TRAP]) begin
      code = EXC_TR;
    end else if (flags[FLAG_SYSCALL]) begin
      code = EXC_SYS;
    end else if (flags[FLAG_BREAK]) begin
      code = EXC_BP;
    end else if (flags[FLAG_ADEL_DATA]) begin
      code    = EXC_ADEL;
      bad_sel = BAD_ADDR;
    end else if (flags[FLAG_ADES_DATA]) begin
      code    = EXC_ADES;
      bad_sel = BAD_ADDR;
    end else if (flags[FLAG_ERET]) begin
      code = EXC_ERET;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between MEM and CP0: commit, flush, redirect.
// Define EXC_CTRL_STATS_EN to build the saturating committed-exception counter.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid_i,
  input  logic [31:0]          mem_pc_i,
  input  logic                 mem_in_delayslot_i,
  input  logic [NUM_FLAGS-1:0] mem_exc_flags_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          cp0_status_i,
  input  logic [31:0]          cp0_cause_i,
  input  logic [31:0]          cp0_epc_i,
  output logic [31:0]          excepttype_o,
  output logic [31:0]          exc_pc_o,
  output logic                 exc_delayslot_o,
  output logic [31:0]          bad_addr_o,
  output logic                 flush_o,
  output logic                 hold_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  input  logic                 redirect_ready_i,
  output logic [31:0]          exc_count_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_e  state, state_next;
  logic [3:0]  flush_cnt;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        ds_q;
  logic [31:0] bad_q;
  logic [31:0] redir_q;

  logic        int_pend;
  logic        detect;
  logic [4:0]  enc_code;
  bad_sel_e    enc_bad_sel;
  logic [31:0] bad_addr_sel;
  logic        unused_cp0;

  assign unused_cp0 = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};

  assign int_pend = cp0_status_i[0] & ~cp0_status_i[1]
                  & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
  assign detect   = (state == IDLE) & mem_valid_i
                  & (int_pend | (|mem_exc_flags_i));

  exc_prio_enc u_prio_enc (
    .flags    (mem_exc_flags_i),
    .int_pend (int_pend),
    .code     (enc_code),
    .bad_sel  (enc_bad_sel)
  );

  always_comb begin
    case (enc_bad_sel)
      BAD_PC:   bad_addr_sel = mem_pc_i;
      BAD_ADDR: bad_addr_sel = mem_addr_i;
      default:  bad_addr_sel = '0;
    endcase
  end

  // Everything CP0 and fetch need is captured at detect; MEM is ignored afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      pc_q    <= '0;
      ds_q    <= 1'b0;
      bad_q   <= '0;
      redir_q <= '0;
    end else if (detect) begin
      code_q  <= enc_code;
      pc_q    <= mem_pc_i;
      ds_q    <= mem_in_delayslot_i;
      bad_q   <= bad_addr_sel;
      redir_q <= (enc_code == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (state == COMMIT) begin
      flush_cnt <= FLUSH_LOAD;
    end else if ((state == FLUSH) && (flush_cnt != '0)) begin
      flush_cnt <= flush_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    excepttype_o     = '0;
    exc_pc_o         = '0;
    exc_delayslot_o  = 1'b0;
    bad_addr_o       = '0;
    flush_o          = 1'b0;
    hold_o           = detect;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state)
      IDLE: begin
        if (detect) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next      = FLUSH;
        excepttype_o    = {27'd0, code_q};
        exc_pc_o        = pc_q;
        exc_delayslot_o = ds_q;
        bad_addr_o      = bad_q;
        flush_o         = 1'b1;
        hold_o          = 1'b1;
      end
      FLUSH: begin
        flush_o = 1'b1;
        hold_o  = 1'b1;
        if (flush_cnt == '0) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        hold_o           = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = redir_q;
        if (redirect_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef EXC_CTRL_STATS_EN
  logic [31:0] exc_count;

  // ERET is a return, not an exception, so it is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count <= '0;
    end else if ((state == COMMIT) && (code_q != EXC_ERET) && (exc_count != 32'hFFFFFFFF)) begin
      exc_count <= exc_count + 32'd1;
    end
  end

  assign exc_count_o = exc_count;
`else
  assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed cases from the test plan plus
// randomized exceptions compared against a priority-table reference model.
module tb_exc_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] VECTOR       = 32'hBFC00380;
  localparam logic [4:0]  CODE_OF_FLAG [9] = '{5'h04, 5'h0a, 5'h0c, 5'h0d, 5'h08,
                                                5'h09, 5'h04, 5'h05, 5'h0e};

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [8:0]  mem_exc_flags_i;
  logic [31:0] mem_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic        hold_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic [31:0] exc_count_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_count = '0;

  logic [8:0]  r_flags;
  logic [31:0] r_status, r_cause;
  logic        r_ip;

  exc_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .EXC_VECTOR   (VECTOR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_exc_flags_i    (mem_exc_flags_i),
    .mem_addr_i         (mem_addr_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .excepttype_o       (excepttype_o),
    .exc_pc_o           (exc_pc_o),
    .exc_delayslot_o    (exc_delayslot_o),
    .bad_addr_o         (bad_addr_o),
    .flush_o            (flush_o),
    .hold_o             (hold_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i),
    .exc_count_o        (exc_count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/excepttype"}, excepttype_o, 32'd0);
    checkOutput({tag, "/exc_pc"}, exc_pc_o, 32'd0);
    checkOutput({tag, "/delayslot"}, 32'(exc_delayslot_o), 32'd0);
    checkOutput({tag, "/bad_addr"}, bad_addr_o, 32'd0);
    checkOutput({tag, "/flush"}, 32'(flush_o), 32'd0);
    checkOutput({tag, "/hold"}, 32'(hold_o), 32'd0);
    checkOutput({tag, "/redir_valid"}, 32'(redirect_valid_o), 32'd0);
    checkOutput({tag, "/redir_pc"}, redirect_pc_o, 32'd0);
    checkOutput({tag, "/count"}, exc_count_o, exp_count);
  endtask

  // Garbage on MEM/CP0 while a sequence is in flight must have no effect
  task automatic scrambleInputs();
    mem_valid_i        = 1'($urandom);
    mem_pc_i           = $urandom;
    mem_in_delayslot_i = 1'($urandom);
    mem_exc_flags_i    = 9'($urandom);
    mem_addr_i         = $urandom;
    cp0_status_i       = $urandom | 32'h0000FF01;
    cp0_cause_i        = $urandom;
    cp0_epc_i          = $urandom;
  endtask

  task automatic applyStimulus(input string name, input logic [8:0] flags,
                               input logic [31:0] pc, input logic ds,
                               input logic [31:0] addr, input logic [31:0] status,
                               input logic [31:0] cause, input logic [31:0] epc,
                               input int stall);
    logic        ip;
    int          first;
    logic [31:0] e_code, e_bad, e_redir;

    ip    = status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 8'd0);
    first = -1;
    for (int b = 8; b >= 0; b--) if (flags[b]) first = b;
    if (ip) begin
      e_code = 32'h01;
      e_bad  = 32'd0;
    end else begin
      e_code = 32'(CODE_OF_FLAG[first]);
      e_bad  = (first == 0) ? pc : ((first == 6 || first == 7) ? addr : 32'd0);
    end
    e_redir = (e_code == 32'h0e) ? epc : VECTOR;

    mem_valid_i        = 1'b1;
    mem_exc_flags_i    = flags;
    mem_pc_i           = pc;
    mem_in_delayslot_i = ds;
    mem_addr_i         = addr;
    cp0_status_i       = status;
    cp0_cause_i        = cause;
    cp0_epc_i          = epc;
    redirect_ready_i   = 1'b0;
    #1;
    checkOutput({name, "/detect_hold"}, 32'(hold_o), 32'd1);
    checkOutput({name, "/detect_type"}, excepttype_o, 32'd0);

    @(posedge clk); #1;
    scrambleInputs();
    #1;
    checkOutput({name, "/commit_type"}, excepttype_o, e_code);
    checkOutput({name, "/commit_pc"}, exc_pc_o, pc);
    checkOutput({name, "/commit_ds"}, 32'(exc_delayslot_o), 32'(ds));
    checkOutput({name, "/commit_bad"}, bad_addr_o, e_bad);
    checkOutput({name, "/commit_flush"}, 32'(flush_o), 32'd1);
    checkOutput({name, "/commit_redir"}, 32'(redirect_valid_o), 32'd0);

    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      @(posedge clk); #1;
      scrambleInputs();
      #1;
      checkOutput({name, "/flush_flush"}, 32'(flush_o), 32'd1);
      checkOutput({name, "/flush_hold"}, 32'(hold_o), 32'd1);
      checkOutput({name, "/flush_type"}, excepttype_o, 32'd0);
      checkOutput({name, "/flush_redir"}, 32'(redirect_valid_o), 32'd0);
    end

    for (int i = 0; i <= stall; i++) begin
      @(posedge clk); #1;
      scrambleInputs();
      redirect_ready_i = (i == stall);
      #1;
      checkOutput({name, "/redir_valid"}, 32'(redirect_valid_o), 32'd1);
      checkOutput({name, "/redir_pc"}, redirect_pc_o, e_redir);
      checkOutput({name, "/redir_hold"}, 32'(hold_o), 32'd1);
      checkOutput({name, "/redir_flush"}, 32'(flush_o), 32'd0);
    end

    @(posedge clk); #1;
`ifdef EXC_CTRL_STATS_EN
    if (e_code != 32'h0e && exp_count != 32'hFFFFFFFF) exp_count++;
`endif
    mem_valid_i      = 1'b0;
    redirect_ready_i = 1'b0;
    #1;
    checkAllZero({name, "/idle"});
  endtask

  initial begin
    $display("[TB] exc_ctrl bench start");
    rst                = 1'b1;
    mem_valid_i        = 1'b0;
    mem_pc_i           = '0;
    mem_in_delayslot_i = 1'b0;
    mem_exc_flags_i    = '0;
    mem_addr_i         = '0;
    cp0_status_i       = '0;
    cp0_cause_i        = '0;
    cp0_epc_i          = '0;
    redirect_ready_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkAllZero("reset");

    applyStimulus("syscall", 9'h010, 32'h80001000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    applyStimulus("ades_ds", 9'h080, 32'h80002004, 1'b1, 32'h00000003, 32'h0, 32'h0, 32'h0, 0);
    applyStimulus("prio_int", 9'h0FF, 32'h80004000, 1'b0, 32'h12345678,
                  32'h00000401, 32'h00000400, 32'h0, 0);
    applyStimulus("prio_noie", 9'h0FF, 32'h80004010, 1'b0, 32'h12345678,
                  32'h00000400, 32'h00000400, 32'h0, 0);
    applyStimulus("eret", 9'h100, 32'h80005000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80003000, 0);
    applyStimulus("backpressure", 9'h020, 32'h80006000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5);

    for (int n = 0; n < 40; n++) begin
      r_flags = 9'($urandom);
      case ($urandom_range(0, 2))
        0:       r_flags = 9'd1 << $urandom_range(0, 8);
        1:       r_flags = 9'd0;
        default: ;
      endcase
      r_status = $urandom;
      r_cause  = $urandom;
      if ($urandom_range(0, 1) == 1) r_status[1:0] = 2'b01;
      r_ip = r_status[0] && !r_status[1] && ((r_cause[15:8] & r_status[15:8]) != 8'd0);
      if (!r_ip && r_flags == 9'd0) r_flags = 9'd1 << $urandom_range(0, 8);
      applyStimulus("random", r_flags, $urandom, 1'($urandom), $urandom,
                    r_status, r_cause, $urandom, $urandom_range(0, 3));
    end

    // Reset pulsed in the second flush cycle must abandon the redirect
    mem_valid_i        = 1'b1;
    mem_exc_flags_i    = 9'h010;
    mem_pc_i           = 32'h80007000;
    cp0_status_i       = 32'h0;
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_mid/flush_before", 32'(flush_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    exp_count = '0;
    #1;
    checkAllZero("rst_mid/after");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_mid/no_redir", 32'(redirect_valid_o), 32'd0);
      checkOutput("rst_mid/no_hold", 32'(hold_o), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
